sensor_display_mux: RTL and testbench

- Parametrised N-channel selector between the sensor front-ends (ADC channels, AHT20 temperature, etc.) and the hex7seg digit drivers.
- Keeps a shadow copy of each channel's latest sample and selects one channel by button pulse or by timed auto-scan.
- Presents the selected value as rate-limited hex nibbles, plus a blank flag and a channel number for the status digit.

---
 rtl/sensor_display_mux.sv | 175 +++++++++++++++++
 tb/tb_sensor_display_mux.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_display_mux.sv
// Shadows N sensor channels and presents one, picked by button or timed scan, as rate-limited hex digits.
// Optional stale-data blanking is enabled with SENSOR_DISPLAY_MUX_STALE_BLANK_EN.
module sensor_display_mux #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned UPDATE_HZ   = 4,
    parameter int unsigned SCAN_TICKS  = 8,
    parameter int unsigned STALE_TICKS = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              next_ch,
    input  logic                              auto_mode,
    input  logic [N_CH*DATA_W-1:0]            ch_data,
    input  logic [N_CH-1:0]                   ch_valid,
    output logic [3:0]                        sel_ch,
    output logic [4*((DATA_W+3)/4)-1:0]       disp_digits,
    output logic                              disp_blank,
    output logic                              update
);

    localparam int unsigned NDIG     = (DATA_W + 3) / 4;
    localparam int unsigned DIG_W    = 4 * NDIG;
    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / UPDATE_HZ;
    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W   = $clog2(SCAN_TICKS + 1);

    // Elaboration-time parameter sanity checks
    if (N_CH < 1 || N_CH > 15) begin : g_bad_nch
        $error("sensor_display_mux: N_CH must be 1..15");
    end
    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_dw
        $error("sensor_display_mux: DATA_W must be 4..32");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("sensor_display_mux: CLK_FREQ_HZ/UPDATE_HZ must be at least 2");
    end
    if (SCAN_TICKS < 1 || STALE_TICKS < 1) begin : g_bad_ticks
        $error("sensor_display_mux: SCAN_TICKS and STALE_TICKS must be at least 1");
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    logic              tick_q;
    logic              pending;
    logic              auto_q;
    logic              refresh_c;
    logic [SCAN_W-1:0] scan_cnt;
    logic [SCAN_W-1:0] scan_nxt_c;
    logic [3:0]        sel_nxt_c;
    logic [3:0]        man_adv_c;
    logic [3:0]        auto_adv_c;

    logic [DATA_W-1:0] shadow [N_CH];
    logic [N_CH-1:0]   seen;
    logic [DATA_W-1:0] sel_data_c;
    logic              sel_seen_c;
    logic              sel_stale_c;
    logic              blank_c;

    assign tick_c    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign refresh_c = tick_q | pending;

    // Next selection: manual wraps through 0, auto scan skips 0
    always_comb begin
        sel_nxt_c  = sel_ch;
        scan_nxt_c = scan_cnt;
        man_adv_c  = (sel_ch >= 4'(N_CH)) ? 4'd0 : sel_ch + 4'd1;
        auto_adv_c = (sel_ch >= 4'(N_CH)) ? 4'd1 : sel_ch + 4'd1;
        if (!auto_mode) begin
            scan_nxt_c = '0;
            if (next_ch) begin
                sel_nxt_c = man_adv_c;
            end
        end else if (!auto_q && sel_ch == 4'd0) begin
            sel_nxt_c  = 4'd1;
            scan_nxt_c = '0;
        end else if (next_ch) begin
            sel_nxt_c  = auto_adv_c;
            scan_nxt_c = '0;
        end else if (tick_c) begin
            if (scan_cnt >= SCAN_W'(SCAN_TICKS - 1)) begin
                sel_nxt_c  = auto_adv_c;
                scan_nxt_c = '0;
            end else begin
                scan_nxt_c = scan_cnt + SCAN_W'(1);
            end
        end
    end

    // Read-out of the selected channel's shadow state
    always_comb begin
        sel_data_c = '0;
        sel_seen_c = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (sel_ch == 4'(k + 1)) begin
                sel_data_c = shadow[k];
                sel_seen_c = seen[k];
            end
        end
    end

`ifdef SENSOR_DISPLAY_MUX_STALE_BLANK_EN
    localparam int unsigned AGE_W = $clog2(STALE_TICKS + 1);

    logic [AGE_W-1:0] age [N_CH];

    // Ticks since last valid, saturating at the stale threshold
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!reset_n || ch_valid[k]) begin
                age[k] <= '0;
            end else if (tick_c && age[k] != AGE_W'(STALE_TICKS)) begin
                age[k] <= age[k] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        sel_stale_c = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (sel_ch == 4'(k + 1)) begin
                sel_stale_c = (age[k] == AGE_W'(STALE_TICKS));
            end
        end
    end
`else
    assign sel_stale_c = 1'b0;
`endif

    assign blank_c = (sel_ch == 4'd0) | ~sel_seen_c | sel_stale_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            tick_q      <= 1'b0;
            pending     <= 1'b0;
            auto_q      <= 1'b0;
            scan_cnt    <= '0;
            sel_ch      <= 4'd0;
            disp_digits <= '0;
            disp_blank  <= 1'b1;
            update      <= 1'b0;
            seen        <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            tick_q   <= tick_c;
            auto_q   <= auto_mode;
            scan_cnt <= scan_nxt_c;
            sel_ch   <= sel_nxt_c;
            // A selection change always wins over a clearing refresh
            if (sel_nxt_c != sel_ch) begin
                pending <= 1'b1;
            end else if (refresh_c) begin
                pending <= 1'b0;
            end
            update <= refresh_c;
            if (refresh_c) begin
                disp_digits <= DIG_W'(sel_data_c);
                disp_blank  <= blank_c;
            end
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (ch_valid[k]) begin
                    shadow[k] <= ch_data[k*DATA_W +: DATA_W];
                    seen[k]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_display_mux.sv
// Bench for sensor_display_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_sensor_display_mux;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned DATA_W      = 12;
    localparam int unsigned CLK_FREQ_HZ = 100;
    localparam int unsigned UPDATE_HZ   = 10;
    localparam int unsigned SCAN_TICKS  = 2;
    localparam int unsigned STALE_TICKS = 3;
    localparam int unsigned TICK_DIV    = CLK_FREQ_HZ / UPDATE_HZ;
    localparam int unsigned NDIG        = (DATA_W + 3) / 4;
    localparam int unsigned DIG_W       = 4 * NDIG;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   next_ch;
    logic                   auto_mode;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic [3:0]             sel_ch;
    logic [DIG_W-1:0]       disp_digits;
    logic                   disp_blank;
    logic                   update;

    int n_pass = 0;
    int n_total = 0;

    sensor_display_mux #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .UPDATE_HZ(UPDATE_HZ), .SCAN_TICKS(SCAN_TICKS), .STALE_TICKS(STALE_TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .next_ch(next_ch), .auto_mode(auto_mode),
        .ch_data(ch_data), .ch_valid(ch_valid), .sel_ch(sel_ch),
        .disp_digits(disp_digits), .disp_blank(disp_blank), .update(update)
    );

    always #5 clk = ~clk;

    // Behavioural model state: time since reset, ticks since each channel's last sample
    int unsigned       m_cyc;
    logic [3:0]        m_sel;
    int                m_scan;
    logic              m_prev_tick;
    logic              m_pending;
    logic              m_auto_prev;
    logic [DATA_W-1:0] m_shadow [N_CH];
    logic              m_seen [N_CH];
    int                m_age [N_CH];
    logic [DIG_W-1:0]  m_digits;
    logic              m_blank;
    logic              m_update;

    task automatic model_edge(input logic r, input logic n, input logic a,
                              input logic [N_CH*DATA_W-1:0] d, input logic [N_CH-1:0] v);
        logic tick;
        logic refresh;
        logic stale;
        int   s;
        int   nsel;
        int   nscan;
        if (!r) begin
            m_cyc = 0; m_sel = 4'd0; m_scan = 0; m_prev_tick = 1'b0; m_pending = 1'b0;
            m_auto_prev = 1'b0; m_digits = '0; m_blank = 1'b1; m_update = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                m_shadow[k] = '0; m_seen[k] = 1'b0; m_age[k] = 0;
            end
        end else begin
            s       = int'(m_sel);
            tick    = (m_cyc % TICK_DIV) == TICK_DIV - 1;
            refresh = m_prev_tick || m_pending;
            m_update = refresh;
            if (refresh) begin
                if (s == 0) begin
                    m_digits = '0;
                    m_blank  = 1'b1;
                end else begin
                    stale = 1'b0;
`ifdef SENSOR_DISPLAY_MUX_STALE_BLANK_EN
                    stale = m_age[s-1] >= int'(STALE_TICKS);
`endif
                    m_digits = DIG_W'(m_shadow[s-1]);
                    m_blank  = !m_seen[s-1] || stale;
                end
            end
            nsel  = s;
            nscan = m_scan;
            if (!a) begin
                nscan = 0;
                if (n) nsel = (s + 1) % (N_CH + 1);
            end else if (!m_auto_prev && s == 0) begin
                nsel = 1; nscan = 0;
            end else if (n) begin
                nsel = s % N_CH + 1; nscan = 0;
            end else if (tick) begin
                if (m_scan + 1 >= int'(SCAN_TICKS)) begin
                    nsel = s % N_CH + 1; nscan = 0;
                end else begin
                    nscan = m_scan + 1;
                end
            end
            for (int k = 0; k < N_CH; k++) begin
                if (v[k]) begin
                    m_shadow[k] = d[k*DATA_W +: DATA_W];
                    m_seen[k]   = 1'b1;
                    m_age[k]    = 0;
                end else if (tick && m_age[k] < 1000) begin
                    m_age[k] = m_age[k] + 1;
                end
            end
            if (nsel != s) m_pending = 1'b1;
            else if (refresh) m_pending = 1'b0;
            m_prev_tick = tick;
            m_auto_prev = a;
            m_sel  = 4'(nsel);
            m_scan = nscan;
            m_cyc++;
        end
    endtask

    // One clock: sample current inputs, advance DUT and model, settle 1ns past the edge
    task automatic clk_step();
        logic r, n, a;
        logic [N_CH*DATA_W-1:0] d;
        logic [N_CH-1:0] v;
        r = reset_n; n = next_ch; a = auto_mode; d = ch_data; v = ch_valid;
        @(posedge clk);
        model_edge(r, n, a, d, v);
        #1;
    endtask

    task automatic pulse_next();
        next_ch = 1'b1;
        clk_step();
        next_ch = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_ch  = 1'($urandom_range(0, 1));
            ch_valid = 4'($urandom);
            ch_data  = {$urandom, $urandom};
            clk_step();
            if ({sel_ch, disp_digits, disp_blank, update} !== {4'd0, DIG_W'(0), 1'b1, 1'b0}) begin
                $display("FAIL reset_state cyc%0d: got sel=%0d dig=%h blank=%b upd=%b, need 0/0/1/0",
                         i, sel_ch, disp_digits, disp_blank, update);
            end else n_pass++;
            n_total++;
        end
        next_ch = 1'b0; ch_valid = '0; reset_n = 1'b1;
        clk_step();
    endtask

    task automatic test_manual_wrap();
        logic [3:0] exp_sel [5];
        exp_sel = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        for (int i = 0; i < 5; i++) begin
            pulse_next();
            if (sel_ch !== exp_sel[i]) begin
                $display("FAIL manual_sel[%0d]: got %0d, need %0d", i, sel_ch, exp_sel[i]);
            end else n_pass++;
            n_total++;
            clk_step();
            if (update !== 1'b1) begin
                $display("FAIL manual_update[%0d]: got %b, need 1", i, update);
            end else n_pass++;
            n_total++;
            clk_step();
        end
        if ({disp_digits, disp_blank} !== {DIG_W'(0), 1'b1}) begin
            $display("FAIL manual_none_blank: got dig=%h blank=%b, need 0/1", disp_digits, disp_blank);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_capture_hold();
        logic seen_upd;
        pulse_next();
        ch_data[DATA_W-1:0] = 12'hA5C;
        ch_valid = 4'b0001;
        clk_step();
        ch_valid = '0;
        repeat (TICK_DIV) clk_step();
        if ({disp_digits, disp_blank} !== {DIG_W'(12'hA5C), 1'b0}) begin
            $display("FAIL capture_latency: got dig=%h blank=%b, need a5c/0", disp_digits, disp_blank);
        end else n_pass++;
        n_total++;
        seen_upd = 1'b0;
        for (int i = 0; i < int'(TICK_DIV) + 2 && !seen_upd; i++) begin
            clk_step();
            seen_upd = update;
        end
        repeat (3) clk_step();
        ch_data[DATA_W-1:0] = 12'h123;
        ch_valid = 4'b0001;
        clk_step();
        ch_valid = '0;
        seen_upd = 1'b0;
        for (int i = 0; i < int'(TICK_DIV) + 2 && !seen_upd; i++) begin
            clk_step();
            seen_upd = update;
            if (!seen_upd) begin
                if (disp_digits !== DIG_W'(12'hA5C)) begin
                    $display("FAIL hold_between_refresh: got %h, need a5c", disp_digits);
                end else n_pass++;
                n_total++;
            end
        end
        if ({seen_upd, disp_digits} !== {1'b1, DIG_W'(12'h123)}) begin
            $display("FAIL hold_next_refresh: got upd=%b dig=%h, need 1/123", seen_upd, disp_digits);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_unseen();
        pulse_next();
        clk_step();
        pulse_next();
        clk_step();
        if ({sel_ch, disp_digits, disp_blank, update} !== {4'd3, DIG_W'(0), 1'b1, 1'b1}) begin
            $display("FAIL unseen_ch3: got sel=%0d dig=%h blank=%b upd=%b, need 3/0/1/1",
                     sel_ch, disp_digits, disp_blank, update);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_auto_scan();
        logic [3:0] prev;
        logic [3:0] exp_seq [3];
        int gap;
        exp_seq = '{4'd3, 4'd4, 4'd1};
        pulse_next();
        pulse_next();
        auto_mode = 1'b1;
        clk_step();
        if (sel_ch !== 4'd1) begin
            $display("FAIL auto_force_ch1: got %0d, need 1", sel_ch);
        end else n_pass++;
        n_total++;
        prev = sel_ch;
        gap = 0;
        while (sel_ch === prev && gap < 25) begin
            clk_step();
            gap++;
        end
        if (sel_ch !== 4'd2) begin
            $display("FAIL auto_first_advance: got %0d after %0d cycles, need 2", sel_ch, gap);
        end else n_pass++;
        n_total++;
        for (int i = 0; i < 3; i++) begin
            prev = sel_ch;
            gap = 0;
            while (sel_ch === prev && gap < 30) begin
                clk_step();
                gap++;
            end
            if ({sel_ch, 8'(gap)} !== {exp_seq[i], 8'(SCAN_TICKS * TICK_DIV)}) begin
                $display("FAIL auto_period[%0d]: got sel=%0d gap=%0d, need %0d/%0d",
                         i, sel_ch, gap, exp_seq[i], SCAN_TICKS * TICK_DIV);
            end else n_pass++;
            n_total++;
        end
        for (int i = 0; i < 40; i++) begin
            if (m_scan == int'(SCAN_TICKS) - 1 && (m_cyc % TICK_DIV) == TICK_DIV - 1) break;
            clk_step();
        end
        prev = sel_ch;
        pulse_next();
        if (sel_ch !== 4'(int'(prev) % N_CH + 1)) begin
            $display("FAIL auto_coincide: got %0d, need %0d", sel_ch, int'(prev) % N_CH + 1);
        end else n_pass++;
        n_total++;
        prev = sel_ch;
        repeat (12) clk_step();
        if (sel_ch !== prev) begin
            $display("FAIL auto_scan_restart: got %0d, need %0d", sel_ch, prev);
        end else n_pass++;
        n_total++;
        auto_mode = 1'b0;
        clk_step();
    endtask

`ifdef SENSOR_DISPLAY_MUX_STALE_BLANK_EN
    task automatic test_stale();
        for (int i = 0; i < 6 && m_sel != 4'd1; i++) begin
            pulse_next();
            clk_step();
        end
        ch_data[DATA_W-1:0] = 12'h7E1;
        ch_valid = 4'b0001;
        clk_step();
        ch_valid = '0;
        repeat (5 * TICK_DIV) clk_step();
        if ({sel_ch, disp_digits, disp_blank} !== {4'd1, DIG_W'(12'h7E1), 1'b1}) begin
            $display("FAIL stale_blank: got sel=%0d dig=%h blank=%b, need 1/7e1/1",
                     sel_ch, disp_digits, disp_blank);
        end else n_pass++;
        n_total++;
        ch_data[DATA_W-1:0] = 12'h0B2;
        ch_valid = 4'b0001;
        clk_step();
        ch_valid = '0;
        repeat (TICK_DIV) clk_step();
        if ({disp_digits, disp_blank} !== {DIG_W'(12'h0B2), 1'b0}) begin
            $display("FAIL stale_recover: got dig=%h blank=%b, need 0b2/0", disp_digits, disp_blank);
        end else n_pass++;
        n_total++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            next_ch = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 79) == 0) auto_mode = ~auto_mode;
            for (int k = 0; k < N_CH; k++) begin
                ch_valid[k] = ($urandom_range(0, 15) == 0);
                ch_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            clk_step();
            if ({sel_ch, disp_digits, disp_blank, update} !== {m_sel, m_digits, m_blank, m_update}) begin
                $display("FAIL random_cyc%0d: got sel=%0d dig=%h blank=%b upd=%b, need %0d/%h/%b/%b",
                         i, sel_ch, disp_digits, disp_blank, update,
                         m_sel, m_digits, m_blank, m_update);
            end else n_pass++;
            n_total++;
        end
        reset_n = 1'b1; next_ch = 1'b0; ch_valid = '0; auto_mode = 1'b0;
        clk_step();
    endtask

    initial begin
        reset_n = 1'b0; next_ch = 1'b0; auto_mode = 1'b0; ch_data = '0; ch_valid = '0;
        test_reset();
        test_manual_wrap();
        test_capture_hold();
        test_unseen();
        test_auto_scan();
`ifdef SENSOR_DISPLAY_MUX_STALE_BLANK_EN
        test_stale();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
